common_fifo_buffer: RTL and testbench
=====================================

// Module: common_fifo_buffer
// PURPOSE
//  Multi-entry in-order FIFO stage with valid/ready handshake on both sides. Sits directly
//  downstream of the 4-to-1 cross buffers and decouples the arbitrated stream from a
//  stalling consumer, absorbing up to BUFFER_DEPTH beats. No combinational ready path
//  from next_i_ready to prev_o_ready.
// PARAMETERS
//  BUFFER_WIDTH  1  payload width in bits (>=1)
//  BUFFER_DEPTH  4  entry count; power of two, >=2
// PORTS
//  clk           in   1               clock; all state updates on posedge
//  reset         in   1               asynchronous, active-low reset (0 = in reset)
//  prev_i_data   in   BUFFER_WIDTH    upstream payload
//  prev_i_valid  in   1               upstream beat valid
//  prev_o_ready  out  1               FIFO can accept a beat this cycle
//  next_o_data   out  BUFFER_WIDTH    head-of-queue payload
//  next_o_valid  out  1               head entry valid
//  next_i_ready  in   1               downstream accepts head this cycle
//  o_count       out  AW+1            occupied entries, AW = $clog2(BUFFER_DEPTH)
//  o_empty       out  1               o_count == 0
//  o_full        out  1               o_count == BUFFER_DEPTH
// BEHAVIOUR
//  - State: wptr, rptr, each AW+1 bits (MSB = wrap bit); storage array DEPTH x WIDTH.
//  - Reset (async, reset==0): wptr=rptr=0; outputs: prev_o_ready=1, next_o_valid=0,
//    o_count=0, o_empty=1, o_full=0; storage not cleared, next_o_data don't-care.
//  - full  = (wptr[AW]!=rptr[AW]) & (wptr[AW-1:0]==rptr[AW-1:0]); empty = wptr==rptr.
//  - prev_o_ready = ~full (registered-state only). next_o_valid = ~empty.
//  - enq = prev_i_valid & prev_o_ready -> mem[wptr[AW-1:0]] <= data, wptr+1 (mod 2^(AW+1)).
//  - deq = next_o_valid & next_i_ready -> rptr+1. next_o_data = mem[rptr[AW-1:0]].
//  - Latency: beat written in cycle N visible on next_o_* in N+1 (no macro).
//  - Simultaneous enq+deq: both happen, count unchanged. When full, enq is refused even
//    if deq occurs same cycle (ready does not look at next_i_ready).
//  - Pointer wrap: index wraps DEPTH-1 -> 0, wrap bit toggles; order strictly preserved.
//  - o_count = wptr - rptr (AW+1 bit modular subtraction).
//  - prev_i_data sampled only on enq; next_o_data stable while next_o_valid & ~next_i_ready.
//  - Reset mid-operation: all queued beats discarded, next_o_valid drops asynchronously.
// CONFIGURATION
//  COMMON_FIFO_BUFFER_BYPASS_EN
//   defined: when empty & prev_i_valid, next_o_valid=1 and next_o_data=prev_i_data
//     combinationally; if next_i_ready also 1, beat passes through, no write, pointers
//     unchanged; if next_i_ready=0, beat is enqueued normally. Latency 0 when empty.
//   undefined: no bypass, next_o_valid depends only on registered state, latency 1.
//  o_empty/o_count always reflect stored entries only, both builds.
// STRUCTURE
//  - Shared header common_buffer_defs.vh: `COMMON_CLOG2 helper macro, pointer-width
//    localparam derivation; used by all common_*_buffer modules.
//  - Sub-module common_fifo_buffer_ptr (AW+1-bit wrapping pointer with increment
//    enable, async active-low reset); instantiated twice (wptr, rptr).
//  - Storage as plain reg array in top module; compile-time check DEPTH power of two.
// TESTING
//  1. WIDTH=8,DEPTH=4: enqueue 0x11,0x22,0x33,0x44 with next_i_ready=0 -> o_full=1,
//     prev_o_ready=0, o_count=4; then ready=1 -> 0x11..0x44 in order over 4 cycles.
//  2. Full + prev_i_valid=1 + next_i_ready=1 same cycle -> only deq, o_count 4->3,
//     offered beat held upstream and accepted next cycle.
//  3. Continuous stream 0x00..0x0F, next_i_ready toggling 1/0 -> 16 beats out in order,
//     no loss/dup, pointers wrap 4x.
//  4. Queue 2 beats, pull reset=0 mid-cycle -> next_o_valid=0, o_count=0 immediately;
//     after release first new beat 0xA5 is first out.
//  5. BYPASS_EN, empty, valid=1 data=0x5A, next_i_ready=1 -> next_o_data=0x5A same
//     cycle, o_count stays 0; without macro -> appears next cycle, o_count 1 then 0.
//  6. Random valid/ready 10k cycles vs scoreboard queue -> order match, o_count matches.

Source files
------------

// File: rtl/common_fifo_buffer_pkg.sv
// Shared sizing helpers for the common FIFO buffer.
// Pointer width is index bits plus one wrap bit.
package common_fifo_buffer_pkg;

    function automatic int fifo_ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit fifo_depth_ok(input int depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/common_fifo_buffer_ptr.sv
// Wrapping FIFO pointer: index bits plus a wrap bit, advances on inc.
// Async active-low reset clears it to zero.
module common_fifo_buffer_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    output logic [PW-1:0] o_ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (inc) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign o_ptr = ptr_q;

endmodule

// File: rtl/common_fifo_buffer.sv
// In-order valid/ready FIFO; ready depends on registered state only.
// Optional empty bypass under COMMON_FIFO_BUFFER_BYPASS_EN.
module common_fifo_buffer
    import common_fifo_buffer_pkg::*;
#(
    parameter int BUFFER_WIDTH = 1,
    parameter int BUFFER_DEPTH = 4,
    localparam int AW = $clog2(BUFFER_DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUFFER_WIDTH-1:0] prev_i_data,
    input  logic                    prev_i_valid,
    output logic                    prev_o_ready,
    output logic [BUFFER_WIDTH-1:0] next_o_data,
    output logic                    next_o_valid,
    input  logic                    next_i_ready,
    output logic [AW:0]             o_count,
    output logic                    o_empty,
    output logic                    o_full
);

    generate
        if (!fifo_depth_ok(BUFFER_DEPTH)) begin : g_bad_depth
            $error("BUFFER_DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [AW:0]             wptr;
    logic [AW:0]             rptr;
    logic [AW-1:0]           widx;
    logic [AW-1:0]           ridx;
    logic                    full;
    logic                    empty;
    logic                    enq;
    logic                    deq;
    logic [BUFFER_WIDTH-1:0] mem_q [BUFFER_DEPTH];

    assign widx  = wptr[AW-1:0];
    assign ridx  = rptr[AW-1:0];
    assign full  = (wptr[AW] != rptr[AW]) && (widx == ridx);
    assign empty = (wptr == rptr);

    assign prev_o_ready = ~full;

`ifdef COMMON_FIFO_BUFFER_BYPASS_EN
    logic pass;

    // An empty queue forwards the offered beat; it is stored only if not taken.
    assign pass         = empty & prev_i_valid;
    assign next_o_valid = ~empty | prev_i_valid;
    assign next_o_data  = empty ? prev_i_data : mem_q[ridx];
    assign enq          = prev_i_valid & ~full & ~(pass & next_i_ready);
    assign deq          = ~empty & next_i_ready;
`else
    assign next_o_valid = ~empty;
    assign next_o_data  = mem_q[ridx];
    assign enq          = prev_i_valid & ~full;
    assign deq          = ~empty & next_i_ready;
`endif

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_q[widx] <= prev_i_data;
        end
    end

    common_fifo_buffer_ptr #(
        .PW (AW + 1)
    ) u_wptr (
        .clk   (clk),
        .reset (reset),
        .inc   (enq),
        .o_ptr (wptr)
    );

    common_fifo_buffer_ptr #(
        .PW (AW + 1)
    ) u_rptr (
        .clk   (clk),
        .reset (reset),
        .inc   (deq),
        .o_ptr (rptr)
    );

    assign o_count = wptr - rptr;
    assign o_empty = empty;
    assign o_full  = full;

endmodule

// File: tb/tb_common_fifo_buffer.sv
// Directed table and sequence checks for common_fifo_buffer (WIDTH=8, DEPTH=4).
// Follows COMMON_FIFO_BUFFER_BYPASS_EN when it is defined for the build.
module tb_common_fifo_buffer;

    logic       clk;
    logic       reset;
    logic [7:0] prev_i_data;
    logic       prev_i_valid;
    logic       prev_o_ready;
    logic [7:0] next_o_data;
    logic       next_o_valid;
    logic       next_i_ready;
    logic [2:0] o_count;
    logic       o_empty;
    logic       o_full;

    int checks;
    int failures;

    common_fifo_buffer #(
        .BUFFER_WIDTH (8),
        .BUFFER_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .prev_i_data  (prev_i_data),
        .prev_i_valid (prev_i_valid),
        .prev_o_ready (prev_o_ready),
        .next_o_data  (next_o_data),
        .next_o_valid (next_o_valid),
        .next_i_ready (next_i_ready),
        .o_count      (o_count),
        .o_empty      (o_empty),
        .o_full       (o_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic       r;
        logic       e_rdy;
        logic       e_vld;
        logic       chk_d;
        logic [7:0] e_d;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs [10];

    function automatic vec_t mk(input logic v, input logic [7:0] d,
                                input logic r, input logic e_rdy,
                                input logic e_vld, input logic chk_d,
                                input logic [7:0] e_d,
                                input logic [2:0] e_cnt);
        vec_t t;
        t.v = v; t.d = d; t.r = r;
        t.e_rdy = e_rdy; t.e_vld = e_vld;
        t.chk_d = chk_d; t.e_d = e_d; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    byte unsigned q[$];

    initial begin
        checks       = 0;
        failures     = 0;
        reset        = 1'b0;
        prev_i_data  = 8'h00;
        prev_i_valid = 1'b0;
        next_i_ready = 1'b0;

        #2;
        chk("rst_ready", prev_o_ready, 1);
        chk("rst_valid", next_o_valid, 0);
        chk("rst_count", o_count, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_full", o_full, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Fill to full, full+valid+ready dequeues only, then drain.
`ifdef COMMON_FIFO_BUFFER_BYPASS_EN
        vecs[0] = mk(1, 8'h11, 0, 1, 1, 1, 8'h11, 0);
`else
        vecs[0] = mk(1, 8'h11, 0, 1, 0, 0, 8'h00, 0);
`endif
        vecs[1] = mk(1, 8'h22, 0, 1, 1, 1, 8'h11, 1);
        vecs[2] = mk(1, 8'h33, 0, 1, 1, 1, 8'h11, 2);
        vecs[3] = mk(1, 8'h44, 0, 1, 1, 1, 8'h11, 3);
        vecs[4] = mk(1, 8'h55, 1, 0, 1, 1, 8'h11, 4);
        vecs[5] = mk(1, 8'h55, 1, 1, 1, 1, 8'h22, 3);
        vecs[6] = mk(0, 8'h00, 1, 1, 1, 1, 8'h33, 3);
        vecs[7] = mk(0, 8'h00, 1, 1, 1, 1, 8'h44, 2);
        vecs[8] = mk(0, 8'h00, 1, 1, 1, 1, 8'h55, 1);
        vecs[9] = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0);

        for (int i = 0; i < 10; i++) begin
            prev_i_valid = vecs[i].v;
            prev_i_data  = vecs[i].d;
            next_i_ready = vecs[i].r;
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), prev_o_ready, vecs[i].e_rdy);
            chk($sformatf("vec%0d_valid", i), next_o_valid, vecs[i].e_vld);
            if (vecs[i].chk_d)
                chk($sformatf("vec%0d_data", i), next_o_data, vecs[i].e_d);
            chk($sformatf("vec%0d_count", i), o_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_full", i), o_full, vecs[i].e_cnt == 3'd4);
            chk($sformatf("vec%0d_empty", i), o_empty, vecs[i].e_cnt == 3'd0);
            step();
        end

        // Streaming 16 beats with toggling ready.
        begin
            int sent;
            int got;
            int cyc;
            sent = 0;
            got  = 0;
            cyc  = 0;
            while (got < 16 && cyc < 200) begin
                prev_i_valid = (sent < 16);
                prev_i_data  = 8'(sent);
                next_i_ready = ((cyc % 2) == 0);
                @(negedge clk);
                if (next_o_valid && next_i_ready) begin
                    chk("stream_data", next_o_data, got);
                    got++;
                end
                if (prev_i_valid && prev_o_ready)
                    sent++;
                step();
                cyc++;
            end
            chk("stream_beats", got, 16);
            prev_i_valid = 1'b0;
            next_i_ready = 1'b0;
            #1;
            chk("stream_empty", o_empty, 1);
        end

        // Empty-queue latency, with and without bypass.
        prev_i_valid = 1'b1;
        prev_i_data  = 8'h5A;
        next_i_ready = 1'b1;
        #3;
`ifdef COMMON_FIFO_BUFFER_BYPASS_EN
        chk("byp_valid0", next_o_valid, 1);
        chk("byp_data0", next_o_data, 8'h5A);
        chk("byp_count0", o_count, 0);
        step();
        prev_i_valid = 1'b0;
        #1;
        chk("byp_count1", o_count, 0);
        chk("byp_valid1", next_o_valid, 0);
`else
        chk("lat_valid0", next_o_valid, 0);
        chk("lat_count0", o_count, 0);
        step();
        prev_i_valid = 1'b0;
        #1;
        chk("lat_valid1", next_o_valid, 1);
        chk("lat_data1", next_o_data, 8'h5A);
        chk("lat_count1", o_count, 1);
        step();
        chk("lat_count2", o_count, 0);
`endif
        next_i_ready = 1'b0;

        // Reset with two beats queued.
        prev_i_valid = 1'b1;
        prev_i_data  = 8'h01;
        step();
        prev_i_data  = 8'h02;
        step();
        prev_i_valid = 1'b0;
        chk("mrst_pre_count", o_count, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("mrst_valid", next_o_valid, 0);
        chk("mrst_count", o_count, 0);
        chk("mrst_empty", o_empty, 1);
        chk("mrst_ready", prev_o_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        step();
        prev_i_valid = 1'b1;
        prev_i_data  = 8'hA5;
        step();
        prev_i_valid = 1'b0;
        chk("mrst_new_valid", next_o_valid, 1);
        chk("mrst_new_data", next_o_data, 8'hA5);
        chk("mrst_new_count", o_count, 1);
        next_i_ready = 1'b1;
        step();
        next_i_ready = 1'b0;
        chk("mrst_drained", o_empty, 1);

        // Random valid/ready against a queue model.
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            int  sz;
            logic ev;
            logic pass;
            prev_i_valid = 1'($urandom_range(0, 1));
            prev_i_data  = 8'($urandom);
            next_i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            sz   = q.size();
            pass = 1'b0;
`ifdef COMMON_FIFO_BUFFER_BYPASS_EN
            ev   = (sz != 0) || prev_i_valid;
            pass = (sz == 0) && prev_i_valid && next_i_ready;
`else
            ev   = (sz != 0);
`endif
            chk("rnd_count", o_count, sz);
            chk("rnd_ready", prev_o_ready, sz < 4);
            chk("rnd_valid", next_o_valid, ev);
            if (ev && next_i_ready) begin
                if (sz != 0) begin
                    chk("rnd_data", next_o_data, q[0]);
                    void'(q.pop_front());
                end else begin
                    chk("rnd_data", next_o_data, prev_i_data);
                end
            end
            if (prev_i_valid && sz < 4 && !pass)
                q.push_back(prev_i_data);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
